// File: rtl/nukv_ht_bucket_join.sv
// nukv_ht_bucket_join: pairs each hash-table entry with its two bucket words and flags key matches.
// Ports: key_data/key_valid/key_ready   - entry {hash, meta, key} from the read-command issuer
//        rddata_data/valid/ready         - bucket words from memory, addr1 word then addr2 word
//        output_data/valid/ready         - {match[1:0], word2, word1, key_data} to value fetch/update
//        miss_count                      - number of results emitted with match == 2'b00
module nukv_ht_bucket_join #(
    parameter int KEY_WIDTH      = 128,
    parameter int META_WIDTH     = 96,
    parameter int HASHADDR_WIDTH = 64,
    parameter int MEMDATA_WIDTH  = 512
) (
    input  logic                                                           clk,
    input  logic                                                           rst_n,
    input  logic [KEY_WIDTH+META_WIDTH+HASHADDR_WIDTH-1:0]                 key_data,
    input  logic                                                           key_valid,
    output logic                                                           key_ready,
    input  logic [MEMDATA_WIDTH-1:0]                                       rddata_data,
    input  logic                                                           rddata_valid,
    output logic                                                           rddata_ready,
    output logic [KEY_WIDTH+META_WIDTH+HASHADDR_WIDTH+2*MEMDATA_WIDTH+1:0] output_data,
    output logic                                                           output_valid,
    input  logic                                                           output_ready,
    output logic [31:0]                                                    miss_count
);
    localparam int E  = KEY_WIDTH + META_WIDTH + HASHADDR_WIDTH;
    localparam int OW = E + 2 * MEMDATA_WIDTH + 2;

    typedef enum logic [1:0] {ST_WAIT_KEY, ST_WAIT_WORD1, ST_WAIT_WORD2, ST_OUTPUT} state_t;
    state_t state_q;

    function automatic logic hit(input logic [MEMDATA_WIDTH-1:0] w, input logic [KEY_WIDTH-1:0] k);
        return w[MEMDATA_WIDTH-1] && (w[KEY_WIDTH-1:0] == k);
    endfunction

    // key_ready is held low while reset is asserted even though the reset state is ST_WAIT_KEY
    assign key_ready    = rst_n && (state_q == ST_WAIT_KEY);
    assign rddata_ready = (state_q == ST_WAIT_WORD1) || (state_q == ST_WAIT_WORD2);

    // The output register doubles as the staging buffer for key, word1 and match[0]; it only
    // has to be stable while output_valid is high, so no separate holding registers are needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT_KEY;
            output_valid <= 1'b0;
            output_data  <= '0;
            miss_count   <= '0;
        end else begin
            case (state_q)
                ST_WAIT_KEY: if (key_valid) begin
                    output_data[E-1:0] <= key_data;
                    state_q            <= ST_WAIT_WORD1;
                end
                ST_WAIT_WORD1: if (rddata_valid) begin
                    output_data[E +: MEMDATA_WIDTH] <= rddata_data;
                    output_data[OW-2]               <= hit(rddata_data, output_data[KEY_WIDTH-1:0]);
                    state_q                         <= ST_WAIT_WORD2;
                end
                ST_WAIT_WORD2: if (rddata_valid) begin
                    output_data[E+MEMDATA_WIDTH +: MEMDATA_WIDTH] <= rddata_data;
                    output_data[OW-1]                             <= hit(rddata_data, output_data[KEY_WIDTH-1:0]);
                    output_valid                                  <= 1'b1;
                    state_q                                       <= ST_OUTPUT;
                end
                ST_OUTPUT: if (output_ready) begin
                    output_valid <= 1'b0;
                    state_q      <= ST_WAIT_KEY;
                    if (output_data[OW-1 -: 2] == 2'b00) miss_count <= miss_count + 32'd1;
                end
                default: state_q <= ST_WAIT_KEY;
            endcase
        end
    end
endmodule
